// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and state definitions for the ALU command sequencer.
package alu_pkg;

  localparam logic [4:0] OP_LDI = 5'b00000;
  localparam logic [4:0] OP_INC = 5'b00001;
  localparam logic [4:0] OP_DEC = 5'b00011;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_ADC = 5'b00101;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_SBB = 5'b00111;
  localparam logic [4:0] OP_AND = 5'b01000;
  localparam logic [4:0] OP_OR  = 5'b01001;
  localparam logic [4:0] OP_XOR = 5'b01010;
  localparam logic [4:0] OP_NOT = 5'b01011;
  localparam logic [4:0] OP_SHL = 5'b10000;
  localparam logic [4:0] OP_SHR = 5'b10001;
  localparam logic [4:0] OP_SAL = 5'b10010;
  localparam logic [4:0] OP_SAR = 5'b10011;
  localparam logic [4:0] OP_ROL = 5'b10100;
  localparam logic [4:0] OP_ROR = 5'b10101;
  localparam logic [4:0] OP_RCL = 5'b10110;
  localparam logic [4:0] OP_RCR = 5'b10111;

  localparam int FL_CF = 5;
  localparam int FL_ZF = 4;
  localparam int FL_NF = 3;
  localparam int FL_VF = 2;
  localparam int FL_PF = 1;
  localparam int FL_AF = 0;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  function automatic logic is_arith(input logic [4:0] op);
    return op inside {OP_INC, OP_DEC, OP_ADD, OP_ADC, OP_SUB, OP_SBB};
  endfunction

  function automatic logic is_logic(input logic [4:0] op);
    return op inside {OP_AND, OP_OR, OP_XOR, OP_NOT};
  endfunction

  function automatic logic is_shift(input logic [4:0] op);
    return op[4:3] == 2'b10;
  endfunction

  // LDI is handled by the sequencer itself, so it is not an ALU-legal op.
  function automatic logic is_legal(input logic [4:0] op);
    return is_arith(op) || is_logic(op) || is_shift(op);
  endfunction

  // Which flag bits an op is allowed to overwrite at commit.
  function automatic logic [5:0] flag_mask(input logic [4:0] op);
    logic [5:0] m;
    m = 6'b000000;
    if (is_arith(op))      m = 6'b111111;
    else if (is_logic(op)) m = 6'b011010;
    else if (is_shift(op)) m = 6'b111010;
    return m;
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREG x 16 operand register file: two asynchronous read ports, one synchronous write port.
module alu_regfile #(
  parameter int NREG = 8,
  parameter int RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [RW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [RW-1:0] raddr_a,
  output logic [15:0]   rdata_a,
  input  logic [RW-1:0] raddr_b,
  output logic [15:0]   rdata_b
);

  logic [15:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer for an external 16-bit ALU: owns operand registers and flags,
// iterates single-bit shift/rotate ops, writes back and returns result plus flags.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter  int NREG  = 8,
  parameter  int CNT_W = 4,
  localparam int RW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_op,
  input  logic [RW-1:0]    cmd_dst,
  input  logic [RW-1:0]    cmd_srca,
  input  logic [RW-1:0]    cmd_srcb,
  input  logic [15:0]      cmd_imm,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [4:0]       alu_f,
  output logic             alu_cin,
  input  logic [15:0]      alu_result,
  input  logic [5:0]       alu_status,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic [5:0]       rsp_flags,
  output logic             rsp_err
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [4:0]       op_q;
  logic [RW-1:0]    dst_q, srcb_q;
  logic [15:0]      work;
  logic [CNT_W-1:0] iter;
  logic [5:0]       flags;
  logic [15:0]      data_q;
  logic             err_q;

  logic             accept, last, we;
  logic [RW-1:0]    waddr;
  logic [15:0]      wdata, rd_a, rd_b;
  logic [5:0]       upd_mask;

  alu_regfile #(.NREG(NREG), .RW(RW)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (cmd_srca),
    .rdata_a (rd_a),
    .raddr_b (srcb_q),
    .rdata_b (rd_b)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (cmd_op == OP_LDI || !is_legal(cmd_op)) ? RESP : EXEC;
      EXEC: if (last) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE:    cmd_ready = !rst;
      EXEC:    last      = (iter == ONE);
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept = cmd_valid && cmd_ready;

  // Single write port shared by LDI (at accept) and ALU commit (last EXEC cycle).
  assign we    = (accept && cmd_op == OP_LDI) || last;
  assign waddr = last ? dst_q : cmd_dst;
  assign wdata = last ? alu_result : cmd_imm;

  // CF tracks every shift iteration so RCL/RCR chain through it; the full mask applies only at commit.
  always_comb begin
    upd_mask = 6'b000000;
    if (state == EXEC) begin
      if (last)                upd_mask = flag_mask(op_q);
      else if (is_shift(op_q)) upd_mask[FL_CF] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      dst_q  <= '0;
      srcb_q <= '0;
      work   <= '0;
      iter   <= '0;
      flags  <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= cmd_op;
        dst_q  <= cmd_dst;
        srcb_q <= cmd_srcb;
        work   <= rd_a;
        iter   <= (is_shift(cmd_op) && cmd_cnt != '0) ? cmd_cnt : ONE;
        if (cmd_op == OP_LDI) begin
          data_q <= cmd_imm;
          err_q  <= 1'b0;
        end else if (!is_legal(cmd_op)) begin
          data_q <= '0;
          err_q  <= 1'b1;
        end else begin
          err_q  <= 1'b0;
        end
      end
      if (state == EXEC) begin
        work  <= alu_result;
        flags <= (flags & ~upd_mask) | (alu_status & upd_mask);
        if (last) data_q <= alu_result;
        else      iter   <= iter - ONE;
      end
    end
  end

  assign alu_a     = work;
  assign alu_b     = rd_b;
  assign alu_f     = op_q;
  assign alu_cin   = flags[FL_CF];
  assign rsp_data  = data_q;
  assign rsp_flags = flags;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl with a behavioural 16-bit ALU on the alu_* ports.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [4:0]  cmd_op;
  logic [2:0]  cmd_dst, cmd_srca, cmd_srcb;
  logic [15:0] cmd_imm;
  logic [3:0]  cmd_cnt;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_f;
  logic        alu_cin;
  logic [5:0]  alu_status;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_data;
  logic [5:0]  rsp_flags;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.NREG(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
    .cmd_imm(cmd_imm), .cmd_cnt(cmd_cnt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_status(alu_status),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  // Behavioural ALU. Flags an op class must not touch are driven to 1 so leaks show up.
  logic [16:0] t;
  logic [15:0] bb, res;
  logic        ci, c, v, af, legal;
  always_comb begin
    t = '0; bb = '0; res = '0; ci = 1'b0; c = 1'b0; v = 1'b0; af = 1'b0; legal = 1'b1;
    case (alu_f)
      OP_INC, OP_ADD, OP_ADC: begin
        bb  = (alu_f == OP_INC) ? 16'h0001 : alu_b;
        ci  = (alu_f == OP_ADC) ? alu_cin : 1'b0;
        t   = {1'b0, alu_a} + {1'b0, bb} + 17'(ci);
        res = t[15:0];
        c   = t[16];
        v   = (alu_a[15] == bb[15]) && (res[15] != alu_a[15]);
        af  = (5'(alu_a[3:0]) + 5'(bb[3:0]) + 5'(ci)) > 5'd15;
      end
      OP_DEC, OP_SUB, OP_SBB: begin
        bb  = (alu_f == OP_DEC) ? 16'h0001 : alu_b;
        ci  = (alu_f == OP_SBB) ? alu_cin : 1'b0;
        t   = {1'b0, alu_a} - {1'b0, bb} - 17'(ci);
        res = t[15:0];
        c   = t[16];
        v   = (alu_a[15] != bb[15]) && (res[15] != alu_a[15]);
        af  = 5'(alu_a[3:0]) < (5'(bb[3:0]) + 5'(ci));
      end
      OP_AND: begin res = alu_a & alu_b; c = 1'b1; v = 1'b1; af = 1'b1; end
      OP_OR:  begin res = alu_a | alu_b; c = 1'b1; v = 1'b1; af = 1'b1; end
      OP_XOR: begin res = alu_a ^ alu_b; c = 1'b1; v = 1'b1; af = 1'b1; end
      OP_NOT: begin res = ~alu_a;        c = 1'b1; v = 1'b1; af = 1'b1; end
      OP_SHL, OP_SAL: begin res = {alu_a[14:0], 1'b0};     c = alu_a[15]; v = 1'b1; af = 1'b1; end
      OP_SHR:         begin res = {1'b0, alu_a[15:1]};     c = alu_a[0];  v = 1'b1; af = 1'b1; end
      OP_SAR:         begin res = {alu_a[15], alu_a[15:1]}; c = alu_a[0]; v = 1'b1; af = 1'b1; end
      OP_ROL:         begin res = {alu_a[14:0], alu_a[15]}; c = alu_a[15]; v = 1'b1; af = 1'b1; end
      OP_ROR:         begin res = {alu_a[0], alu_a[15:1]};  c = alu_a[0];  v = 1'b1; af = 1'b1; end
      OP_RCL:         begin res = {alu_a[14:0], alu_cin};   c = alu_a[15]; v = 1'b1; af = 1'b1; end
      OP_RCR:         begin res = {alu_cin, alu_a[15:1]};   c = alu_a[0];  v = 1'b1; af = 1'b1; end
      default: legal = 1'b0;
    endcase
    alu_result = res;
    alu_status = legal ? {c, (res == 16'h0), res[15], v, ~^res[7:0], af} : 6'b000000;
  end

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  dst, sa, sb;
    logic [15:0] imm;
    logic [3:0]  cnt;
    logic [15:0] data;
    logic [5:0]  flags;
    logic        err;
    int          lat;
    int          hold;
  } vec_t;

  vec_t tbl[18];
  vec_t sb_q[$];

  function automatic vec_t mk(logic [4:0] op, logic [2:0] dst, logic [2:0] sa, logic [2:0] sb,
                              logic [15:0] imm, logic [3:0] cnt, logic [15:0] data,
                              logic [5:0] flags, logic err, int lat, int hold);
    vec_t r;
    r.op = op; r.dst = dst; r.sa = sa; r.sb = sb; r.imm = imm; r.cnt = cnt;
    r.data = data; r.flags = flags; r.err = err; r.lat = lat; r.hold = hold;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic run_cmd(input vec_t v, input int idx);
    vec_t e;
    int lat;
    wait_ready();
    cmd_op = v.op; cmd_dst = v.dst; cmd_srca = v.sa; cmd_srcb = v.sb;
    cmd_imm = v.imm; cmd_cnt = v.cnt; cmd_valid = 1'b1;
    sb_q.push_back(v);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    chk($sformatf("rsp_valid[%0d]", idx), {31'd0, rsp_valid}, 32'd1);
    e = sb_q.pop_front();
    chk($sformatf("latency[%0d]", idx), lat, e.lat);
    chk($sformatf("data[%0d]", idx), {16'd0, rsp_data}, {16'd0, e.data});
    chk($sformatf("flags[%0d]", idx), {26'd0, rsp_flags}, {26'd0, e.flags});
    chk($sformatf("err[%0d]", idx), {31'd0, rsp_err}, {31'd0, e.err});
    for (int k = 0; k < e.hold; k++) begin
      @(negedge clk);
      chk($sformatf("hold[%0d.%0d]", idx, k),
          {7'd0, rsp_valid, rsp_data, rsp_flags, rsp_err, cmd_ready},
          {7'd0, 1'b1, e.data, e.flags, e.err, 1'b0});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk($sformatf("rsp_drop[%0d]", idx), {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(OP_LDI, 1, 0, 0, 16'hFFFF, 0, 16'hFFFF, 6'b000000, 0, 1, 0);
    tbl[1]  = mk(OP_LDI, 2, 0, 0, 16'h0001, 0, 16'h0001, 6'b000000, 0, 1, 0);
    tbl[2]  = mk(OP_ADD, 3, 1, 2, 16'h0000, 0, 16'h0000, 6'b110011, 0, 2, 0);
    tbl[3]  = mk(OP_ADC, 4, 2, 2, 16'h0000, 0, 16'h0003, 6'b000010, 0, 2, 0);
    tbl[4]  = mk(OP_SUB, 5, 0, 2, 16'h0000, 0, 16'hFFFF, 6'b101011, 0, 2, 0);
    tbl[5]  = mk(OP_LDI, 1, 0, 0, 16'h1234, 0, 16'h1234, 6'b101011, 0, 1, 0);
    tbl[6]  = mk(OP_ROL, 6, 1, 0, 16'h0000, 4, 16'h2341, 6'b100011, 0, 5, 0);
    tbl[7]  = mk(OP_ROL, 6, 1, 0, 16'h0000, 0, 16'h2468, 6'b000001, 0, 2, 0);
    tbl[8]  = mk(OP_SUB, 5, 0, 2, 16'h0000, 0, 16'hFFFF, 6'b101011, 0, 2, 0);
    tbl[9]  = mk(OP_LDI, 1, 0, 0, 16'h8000, 0, 16'h8000, 6'b101011, 0, 1, 0);
    tbl[10] = mk(OP_RCL, 1, 1, 0, 16'h0000, 2, 16'h0003, 6'b000011, 0, 3, 0);
    tbl[11] = mk(OP_XOR, 7, 1, 1, 16'h0000, 0, 16'h0000, 6'b010011, 0, 2, 0);
    tbl[12] = mk(5'b01100, 1, 1, 6, 16'hBEEF, 0, 16'h0000, 6'b010011, 1, 1, 3);
    tbl[13] = mk(OP_ADD, 7, 1, 6, 16'h0000, 0, 16'h246B, 6'b000000, 0, 2, 0);
    tbl[14] = mk(OP_NOT, 3, 3, 0, 16'h0000, 0, 16'hFFFF, 6'b001010, 0, 2, 0);
    tbl[15] = mk(OP_SHR, 3, 3, 0, 16'h0000, 15, 16'h0001, 6'b100000, 0, 16, 0);
    tbl[16] = mk(OP_SBB, 4, 2, 0, 16'h0000, 5, 16'h0000, 6'b010010, 0, 2, 0);
    tbl[17] = mk(5'b11000, 2, 2, 2, 16'h1111, 3, 16'h0000, 6'b010010, 1, 1, 0);

    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_dst = '0; cmd_srca = '0; cmd_srcb = '0; cmd_imm = '0; cmd_cnt = '0;
    repeat (2) @(negedge clk);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("reset_rsp", {8'd0, rsp_valid, rsp_data, rsp_flags, rsp_err}, 32'd0);
    rst = 1'b0;
    #1 chk("post_reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 18; i++) run_cmd(tbl[i], i);

    // Reset in the middle of a long shift: no commit, everything back to zero.
    wait_ready();
    cmd_op = OP_SHL; cmd_dst = 1; cmd_srca = 3; cmd_srcb = 0; cmd_cnt = 8; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_exec_busy", {30'd0, rsp_valid, cmd_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_in_reset", {30'd0, rsp_valid, cmd_ready}, 32'd0);
    rst = 1'b0;
    #1 chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("abort_idle[%0d]", k), {30'd0, rsp_valid, cmd_ready}, 32'd1);
    end
    run_cmd(mk(OP_ADD, 3, 6, 5, 16'h0000, 0, 16'h0000, 6'b010010, 0, 2, 0), 100);
    run_cmd(mk(OP_OR, 4, 1, 7, 16'h0000, 0, 16'h0000, 6'b010010, 0, 2, 0), 101);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
